wb_grf: RTL and testbench
=========================

WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL use one clock and SHALL reset asynchronously, active-low.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; reset=0 SHALL clear state immediately, without waiting for a clock edge.
REQ-004 W_opcode  in  6  opcode of the instruction in the W stage.
REQ-005 W_func  in  6  funct field of the instruction in the W stage.
REQ-006 W_wdata  in  32  writeback value.
REQ-007 W_rd  in  5  destination register; jal arrives here already set to 31.
REQ-008 W_pc  in  32  PC of the instruction in the W stage.
REQ-009 D_rs, D_rt  in  5 each  read addresses from the D stage.
REQ-010 D_rs_data, D_rt_data  out  32 each  read data, combinational.
REQ-011 trace_valid  out  1  one-cycle commit pulse.
REQ-012 trace_pc, trace_data  out  32 each  PC and value of the committed write.
REQ-013 trace_rd  out  5  register of the committed write.
REQ-014 wr_count  out  32  number of committed writes.

Function
REQ-015 Write-enable we SHALL be 1 when W_opcode is one of 0x0D ori, 0x0F lui, 0x23 lw or 0x03 jal.
REQ-016 we SHALL also be 1 when W_opcode=0x00 and W_func is one of 0x20, 0x21, 0x22, 0x23 or 0x2A.
REQ-017 we SHALL be 0 for every other opcode/func pair, including nop (all zeros), jr (func 0x08), sw (0x2B) and beq (0x04).
REQ-018 Commit condition: we=1 and W_rd!=0.
REQ-019 On a rising edge with commit=1, the block SHALL write reg[W_rd] <= W_wdata.
REQ-020 A write with W_rd=0 SHALL be discarded; reg[0] SHALL always read 0.
REQ-021 Read path: D_rs_data = 0 when D_rs=0.
REQ-022 Read path: D_rs_data = W_wdata when commit=1 and D_rs=W_rd (same-cycle internal bypass).
REQ-023 Read path: otherwise D_rs_data = reg[D_rs].
REQ-024 D_rt_data SHALL follow REQ-021..REQ-023 with D_rt in place of D_rs.
REQ-025 Trace registers SHALL load on every edge.
REQ-026 trace_valid <= commit.
REQ-027 When commit=1, trace_pc/trace_rd/trace_data SHALL capture W_pc/W_rd/W_wdata.
REQ-028 When commit=0, trace_pc/trace_rd/trace_data SHALL hold their previous values.
REQ-029 Trace latency SHALL be exactly 1 cycle after the write edge.
REQ-030 wr_count SHALL increment by 1 on each edge with commit=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 Back-to-back commits to the same register SHALL leave the later value stored, and each commit SHALL produce its own trace pulse.
REQ-032 Reads of a register in the cycle after it was written SHALL return the stored value; no bypass is needed.

Reset
REQ-033 While reset=0, all 32 registers, trace_valid, trace_pc, trace_rd, trace_data and wr_count SHALL be 0.
REQ-034 Writes SHALL be ignored while reset=0.
REQ-035 Reset asserted in the same cycle as a commit SHALL win: no register write, no trace pulse, no count increment.
REQ-036 The first commit SHALL be accepted on the first rising edge after reset returns to 1.

Verification
REQ-037 Reset, then read D_rs=5, D_rt=31 -> both data outputs 0, wr_count=0, trace_valid=0.
REQ-038 W_opcode=0x0D, W_rd=8, W_wdata=0x1234, W_pc=0x3000, D_rs=8 -> D_rs_data=0x1234 before the edge (bypass) and after the edge (stored); next cycle trace_valid=1, trace_pc=0x3000, trace_rd=8, trace_data=0x1234, wr_count=1.
REQ-039 R-type func 0x20 to W_rd=0 with W_wdata=0xFFFF -> reg0 stays 0, trace_valid=0, wr_count unchanged.
REQ-040 sw (0x2B) with W_rd=9 and W_wdata=0xAAAA -> reg9 unchanged, no trace pulse; nop (all zeros) -> no write.
REQ-041 lw to reg 3 with value 1, then jal with W_rd=31 and value 0x3008 on consecutive cycles -> two consecutive trace pulses, regs 3 and 31 hold 1 and 0x3008, wr_count=2.
REQ-042 Preload wr_count=0xFFFFFFFF via forced commits, then one more commit -> wr_count=0; separately, drop reset to 0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_grf.sv
// Writeback-stage general register file: 31 writable 32-bit registers, a
// same-cycle write-to-read bypass, a one-cycle commit trace and a commit counter.
module wb_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  W_opcode,
    input  logic [5:0]  W_func,
    input  logic [31:0] W_wdata,
    input  logic [4:0]  W_rd,
    input  logic [31:0] W_pc,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_data,
    output logic [4:0]  trace_rd,
    output logic [31:0] wr_count
);

    logic [31:0] regs_r [0:31];
    logic        we_s;
    logic        commit_s;
    logic        trace_valid_r;
    logic [31:0] trace_pc_r;
    logic [31:0] trace_data_r;
    logic [4:0]  trace_rd_r;
    logic [31:0] wr_count_r;

    function automatic logic decode_we(input logic [5:0] opcode, input logic [5:0] func);
        logic we;
        case (opcode)
            6'h0D, 6'h0F, 6'h23, 6'h03: we = 1'b1;
            6'h00: begin
                case (func)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h2A: we = 1'b1;
                    default: we = 1'b0;
                endcase
            end
            default: we = 1'b0;
        endcase
        return we;
    endfunction

    // Gating with reset keeps the bypass silent while the file is held cleared.
    assign we_s     = decode_we(W_opcode, W_func);
    assign commit_s = we_s && (W_rd != 5'd0) && reset;

    // rs read port: zero register, then same-cycle bypass, then stored value
    always_comb begin
        D_rs_data = 32'd0;
        if (D_rs == 5'd0) begin
            D_rs_data = 32'd0;
        end else if (commit_s && (D_rs == W_rd)) begin
            D_rs_data = W_wdata;
        end else begin
            D_rs_data = regs_r[D_rs];
        end
    end

    // rt read port: same priority as rs
    always_comb begin
        D_rt_data = 32'd0;
        if (D_rt == 5'd0) begin
            D_rt_data = 32'd0;
        end else if (commit_s && (D_rt == W_rd)) begin
            D_rt_data = W_wdata;
        end else begin
            D_rt_data = regs_r[D_rt];
        end
    end

    // Register array; entry 0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (commit_s) begin
            regs_r[W_rd] <= W_wdata;
        end
    end

    // Commit trace and counter; fields hold their last commit between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid_r <= 1'b0;
            trace_pc_r    <= 32'd0;
            trace_data_r  <= 32'd0;
            trace_rd_r    <= 5'd0;
            wr_count_r    <= 32'd0;
        end else begin
            trace_valid_r <= commit_s;
            if (commit_s) begin
                trace_pc_r   <= W_pc;
                trace_data_r <= W_wdata;
                trace_rd_r   <= W_rd;
                wr_count_r   <= wr_count_r + 32'd1;
            end
        end
    end

    assign trace_valid = trace_valid_r;
    assign trace_pc    = trace_pc_r;
    assign trace_data  = trace_data_r;
    assign trace_rd    = trace_rd_r;
    assign wr_count    = wr_count_r;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: trace pulses are scoreboarded per cycle,
// register reads and the commit counter are checked against a reference model.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [5:0]  W_opcode;
    logic [5:0]  W_func;
    logic [31:0] W_wdata;
    logic [4:0]  W_rd;
    logic [31:0] W_pc;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_data;
    logic [4:0]  trace_rd;
    logic [31:0] wr_count;

    wb_grf dut (
        .clk(clk), .reset(reset),
        .W_opcode(W_opcode), .W_func(W_func), .W_wdata(W_wdata),
        .W_rd(W_rd), .W_pc(W_pc), .D_rs(D_rs), .D_rt(D_rt),
        .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_data(trace_data), .trace_rd(trace_rd), .wr_count(wr_count)
    );

    typedef struct {
        int          due;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rd;
        logic       cm;
    } case_t;

    trace_t      sb[$];
    logic [31:0] model [0:31];
    logic [31:0] exp_count;
    logic [31:0] last_pc;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    logic        pend_cm;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    int          cyc;
    int          checks;
    int          passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rd,
                         input logic [31:0] data, input logic [31:0] pc, input logic cm);
        W_opcode  = op;
        W_func    = fn;
        W_rd      = rd;
        W_wdata   = data;
        W_pc      = pc;
        pend_cm   = cm;
        pend_rd   = rd;
        pend_data = data;
        if (cm) sb.push_back('{due: cyc + 1, pc: pc, rd: rd, data: data});
    endtask

    task automatic nop();
        drive(6'h00, 6'h00, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // One clock: update the model at the edge, then score the trace outputs.
    task automatic step();
        trace_t e;
        @(posedge clk);
        cyc = cyc + 1;
        if (pend_cm) begin
            model[pend_rd] = pend_data;
            exp_count = exp_count + 32'd1;
        end
        pend_cm = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if ({trace_valid, trace_pc, trace_rd, trace_data} !== {1'b1, e.pc, e.rd, e.data})
                $display("FAIL trace_commit cyc %0d: got v=%b pc=%h rd=%0d data=%h expected v=1 pc=%h rd=%0d data=%h",
                         cyc, trace_valid, trace_pc, trace_rd, trace_data, e.pc, e.rd, e.data);
            else passed++;
            last_pc = e.pc; last_rd = e.rd; last_data = e.data;
        end else begin
            if ({trace_valid, trace_pc, trace_rd, trace_data} !== {1'b0, last_pc, last_rd, last_data})
                $display("FAIL trace_idle cyc %0d: got v=%b pc=%h rd=%0d data=%h expected v=0 pc=%h rd=%0d data=%h",
                         cyc, trace_valid, trace_pc, trace_rd, trace_data, last_pc, last_rd, last_data);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        D_rs = 5'd5; D_rt = 5'd31;
        drive(6'h0D, 6'h00, 5'd5, 32'h0000_0055, 32'h0000_1000, 1'b0);
        #1;
        checks++;
        if ({D_rs_data, D_rt_data, wr_count} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL reset_reads: got rs=%h rt=%h cnt=%h expected all 0", D_rs_data, D_rt_data, wr_count);
        else passed++;
        step();
        drive(6'h0D, 6'h00, 5'd5, 32'h0000_0055, 32'h0000_1000, 1'b0);
        step();
        reset = 1'b1;
        nop();
        #1;
        checks++;
        if ({D_rs_data, D_rt_data, wr_count} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL reset_ignores_write: got rs=%h rt=%h cnt=%h expected all 0", D_rs_data, D_rt_data, wr_count);
        else passed++;
    endtask

    task automatic test_ori_bypass();
        D_rs = 5'd8;
        drive(6'h0D, 6'h00, 5'd8, 32'h0000_1234, 32'h0000_3000, 1'b1);
        #1;
        checks++;
        if (D_rs_data !== 32'h0000_1234) $display("FAIL ori_bypass: got %h expected %h", D_rs_data, 32'h0000_1234);
        else passed++;
        step();
        nop();
        #1;
        checks++;
        if (D_rs_data !== 32'h0000_1234) $display("FAIL ori_stored: got %h expected %h", D_rs_data, 32'h0000_1234);
        else passed++;
        checks++;
        if (wr_count !== 32'd1) $display("FAIL ori_count: got %0d expected 1", wr_count);
        else passed++;
    endtask

    task automatic test_decode();
        case_t tbl[17];
        logic [31:0] data;
        tbl = '{'{6'h00, 6'h21, 5'd9,  1'b1}, '{6'h00, 6'h20, 5'd0,  1'b0},
                '{6'h0D, 6'h00, 5'd0,  1'b0}, '{6'h2B, 6'h00, 5'd9,  1'b0},
                '{6'h00, 6'h00, 5'd9,  1'b0}, '{6'h00, 6'h08, 5'd9,  1'b0},
                '{6'h04, 6'h00, 5'd9,  1'b0}, '{6'h00, 6'h24, 5'd9,  1'b0},
                '{6'h0D, 6'h00, 5'd10, 1'b1}, '{6'h0F, 6'h00, 5'd11, 1'b1},
                '{6'h23, 6'h00, 5'd12, 1'b1}, '{6'h03, 6'h00, 5'd13, 1'b1},
                '{6'h00, 6'h20, 5'd14, 1'b1}, '{6'h00, 6'h21, 5'd15, 1'b1},
                '{6'h00, 6'h22, 5'd16, 1'b1}, '{6'h00, 6'h23, 5'd17, 1'b1},
                '{6'h00, 6'h2A, 5'd18, 1'b1}};
        for (int i = 0; i < 17; i++) begin
            data = (i == 1) ? 32'h0000_FFFF : (i == 3) ? 32'h0000_AAAA : $urandom;
            D_rs = tbl[i].rd; D_rt = tbl[i].rd;
            drive(tbl[i].op, tbl[i].fn, tbl[i].rd, data, 32'h0000_4000 + 32'(i * 4), tbl[i].cm);
            #1;
            checks++;
            if (D_rs_data !== (tbl[i].cm ? data : model[tbl[i].rd]))
                $display("FAIL decode_bypass[%0d]: got %h expected %h", i, D_rs_data,
                         tbl[i].cm ? data : model[tbl[i].rd]);
            else passed++;
            step();
            nop();
            #1;
            checks++;
            if ({D_rt_data, wr_count} !== {model[tbl[i].rd], exp_count})
                $display("FAIL decode_after[%0d]: got data=%h cnt=%0d expected data=%h cnt=%0d",
                         i, D_rt_data, wr_count, model[tbl[i].rd], exp_count);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        D_rs = 5'd3; D_rt = 5'd31;
        drive(6'h23, 6'h00, 5'd3, 32'h0000_0001, 32'h0000_3004, 1'b1);
        step();
        drive(6'h03, 6'h00, 5'd31, 32'h0000_3008, 32'h0000_3008, 1'b1);
        #1;
        checks++;
        if ({D_rs_data, D_rt_data} !== {32'h0000_0001, 32'h0000_3008})
            $display("FAIL b2b_reads: got rs=%h rt=%h expected rs=00000001 rt=00003008", D_rs_data, D_rt_data);
        else passed++;
        step();
        drive(6'h0D, 6'h00, 5'd5, 32'h0000_00AA, 32'h0000_300C, 1'b1);
        step();
        drive(6'h0F, 6'h00, 5'd5, 32'h00BB_0000, 32'h0000_3010, 1'b1);
        step();
        nop();
        #1;
        checks++;
        if ({D_rs_data, D_rt_data} !== {32'h0000_0001, 32'h0000_3008})
            $display("FAIL b2b_stored: got rs=%h rt=%h expected rs=00000001 rt=00003008", D_rs_data, D_rt_data);
        else passed++;
        D_rs = 5'd5;
        #1;
        checks++;
        if ({D_rs_data, wr_count} !== {32'h00BB_0000, exp_count})
            $display("FAIL b2b_same_reg: got data=%h cnt=%0d expected data=00bb0000 cnt=%0d", D_rs_data, wr_count, exp_count);
        else passed++;
    endtask

    task automatic test_wrap();
        force dut.wr_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_r;
        exp_count = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (wr_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h expected ffffffff", wr_count);
        else passed++;
        drive(6'h0D, 6'h00, 5'd20, 32'h0000_0777, 32'h0000_3100, 1'b1);
        step();
        nop();
        #1;
        checks++;
        if ({wr_count, exp_count} !== {32'd0, 32'd0}) $display("FAIL wrap_count: got %h expected 00000000", wr_count);
        else passed++;
    endtask

    task automatic test_async_reset();
        drive(6'h0D, 6'h00, 5'd21, 32'h0000_BEEF, 32'h0000_5000, 1'b1);
        step();
        nop();
        D_rs = 5'd21; D_rt = 5'd31;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({trace_valid, trace_pc, trace_rd, trace_data, wr_count, D_rs_data, D_rt_data} !== 166'd0)
            $display("FAIL async_reset: got v=%b pc=%h rd=%0d data=%h cnt=%h rs=%h rt=%h expected all 0",
                     trace_valid, trace_pc, trace_rd, trace_data, wr_count, D_rs_data, D_rt_data);
        else passed++;
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        exp_count = 32'd0;
        last_pc = 32'd0; last_rd = 5'd0; last_data = 32'd0;
        D_rs = 5'd22;
        drive(6'h0D, 6'h00, 5'd22, 32'h0000_1111, 32'h0000_5004, 1'b0);
        step();
        reset = 1'b1;
        nop();
        #1;
        checks++;
        if ({D_rs_data, wr_count} !== {32'd0, 32'd0})
            $display("FAIL reset_wins: got data=%h cnt=%0d expected 0 0", D_rs_data, wr_count);
        else passed++;
        drive(6'h0D, 6'h00, 5'd22, 32'h0000_2222, 32'h0000_5008, 1'b1);
        step();
        nop();
        #1;
        checks++;
        if ({D_rs_data, wr_count} !== {32'h0000_2222, 32'd1})
            $display("FAIL first_commit: got data=%h cnt=%0d expected 00002222 1", D_rs_data, wr_count);
        else passed++;
    endtask

    initial begin
        checks = 0; passed = 0; cyc = 0;
        exp_count = 32'd0; pend_cm = 1'b0; pend_rd = 5'd0; pend_data = 32'd0;
        last_pc = 32'd0; last_rd = 5'd0; last_data = 32'd0;
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        reset = 1'b0;
        D_rs = 5'd0; D_rt = 5'd0;
        nop();
        test_reset();
        test_ori_bypass();
        test_decode();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        step();
        checks++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
